// File: rtl/sequential_multiplier.sv
// Free-running digit-serial unsigned multiplier: LOAD captures operands, then
// WIDTH/DIGIT CALC cycles each accumulate one DIGIT-wide slice of the multiplier.
module sequential_multiplier #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic [2*WIDTH-1:0]   result,
  output logic                 busy,
  output logic                 done
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  typedef enum logic {S_LOAD = 1'b0, S_CALC = 1'b1} state_e;

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     a_q, a_d, b_q, b_d, b_sh;
  logic [2*WIDTH-1:0]   acc_q, acc_d, res_q, res_d, pp, sum;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 done_q, done_d, last;
  logic [DIGIT-1:0]     dig;
  logic [31:0]          sh;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_LOAD;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_LOAD:  state_d = S_CALC;
      S_CALC:  if (last) state_d = S_LOAD;
      default: state_d = S_LOAD;
    endcase
  end

  // Outputs
  always_comb begin
    busy   = (state_q == S_CALC);
    done   = done_q;
    result = res_q;
  end

  // Partial product of the current multiplier digit, aligned to its weight
  always_comb begin
    last = (cnt_q == CW'(NDIG - 1));
    sh   = 32'(cnt_q) * 32'(DIGIT);
    b_sh = b_q >> sh;
    dig  = b_sh[DIGIT-1:0];
    pp   = ({{WIDTH{1'b0}}, a_q} * {{(2*WIDTH-DIGIT){1'b0}}, dig}) << sh;
    sum  = acc_q + pp;
  end

  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    acc_d  = acc_q;
    cnt_d  = cnt_q;
    res_d  = res_q;
    done_d = 1'b0;
    case (state_q)
      S_LOAD: begin
        a_d   = a;
        b_d   = b;
        acc_d = '0;
        cnt_d = '0;
      end
      S_CALC: begin
        acc_d = sum;
        cnt_d = cnt_q + CW'(1);
        if (last) begin
          res_d  = sum;
          done_d = 1'b1;
          cnt_d  = '0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_q    <= '0;
      b_q    <= '0;
      acc_q  <= '0;
      cnt_q  <= '0;
      res_q  <= '0;
      done_q <= 1'b0;
    end else begin
      a_q    <= a_d;
      b_q    <= b_d;
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      res_q  <= res_d;
      done_q <= done_d;
    end
  end

endmodule

// File: tb/tb_sequential_multiplier.sv
// Scoreboard bench: stimulus pushes a*b at each predicted capture edge, a negedge
// monitor pops on done and checks busy/done timing and result hold.
module tb_sequential_multiplier;
  localparam int WIDTH = 8;
  localparam int DIGIT = 4;
  localparam int K     = WIDTH / DIGIT;

  logic               clk, reset;
  logic [WIDTH-1:0]   a, b;
  logic [2*WIDTH-1:0] result;
  logic               busy, done;

  sequential_multiplier #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
    .clk(clk), .reset(reset), .a(a), .b(b),
    .result(result), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [2*WIDTH-1:0] q[$];
  int   ph       = 0;
  logic exp_busy = 1'b0;
  logic exp_done = 1'b0;
  logic rst_edge = 1'b0;
  logic armed    = 1'b0;
  logic [2*WIDTH-1:0] hold = '0;

  function automatic void chk(string nm, logic [31:0] got, logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, got, want, $time);
    end
  endfunction

  // Engine timing: LOAD edge captures, K CALC edges, result after the K-th.
  task automatic step(input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib, input logic r);
    a = ia; b = ib; reset = r;
    @(posedge clk);
    rst_edge = r;
    if (r) begin
      ph = 0;
      q.delete();
      exp_done = 1'b0;
    end else begin
      exp_done = (ph == K);
      if (ph == 0) q.push_back((2*WIDTH)'(ia) * (2*WIDTH)'(ib));
      ph = (ph == K) ? 0 : ph + 1;
    end
    exp_busy = (ph != 0);
    armed = 1'b1;
    #1;
  endtask

  always @(negedge clk) begin
    if (armed) begin
      chk("busy", 32'(busy), 32'(exp_busy));
      chk("done", 32'(done), 32'(exp_done));
      if (rst_edge) begin
        chk("reset_result", 32'(result), 32'h0);
        hold = '0;
      end else if (done) begin
        if (q.size() == 0) begin
          chk("unexpected_done", 32'(q.size()), 32'h1);
        end else begin
          hold = q.pop_front();
          chk("product", 32'(result), 32'(hold));
        end
      end else begin
        chk("result_hold", 32'(result), 32'(hold));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    a = '0; b = '0; reset = 1'b1;
    // Reset then 3*5
    step(8'h03, 8'h05, 1'b1);
    chk("r23_rst", 32'(result), 32'h0);
    repeat (3) step(8'h03, 8'h05, 1'b0);
    chk("r23_res", 32'(result), 32'h000F);
    chk("r23_done", 32'(done), 32'h1);
    // Max operands, then zero multiplicand with same latency
    repeat (3) step(8'hFF, 8'hFF, 1'b0);
    chk("r24_max", 32'(result), 32'hFE01);
    repeat (3) step(8'h00, 8'hA5, 1'b0);
    chk("r24_zero", 32'(result), 32'h0);
    chk("r24_done", 32'(done), 32'h1);
    // Operand change during CALC must not disturb in-flight product
    step(8'h12, 8'h34, 1'b0);
    repeat (2) step(8'h07, 8'h09, 1'b0);
    chk("r25_first", 32'(result), 32'h03A8);
    repeat (3) step(8'h07, 8'h09, 1'b0);
    chk("r25_next", 32'(result), 32'h003F);
    // Reset on first CALC edge aborts
    step(8'hFF, 8'hFF, 1'b0);
    step(8'hFF, 8'hFF, 1'b1);
    chk("r26_res", 32'(result), 32'h0);
    chk("r26_busy", 32'(busy), 32'h0);
    step(8'hFF, 8'hFF, 1'b0);
    chk("r26_restart", 32'(busy), 32'h1);
    repeat (2) step(8'hFF, 8'hFF, 1'b0);
    chk("r26_after", 32'(result), 32'hFE01);
    // Continuous run
    repeat (12) step(8'h10, 8'h10, 1'b0);
    chk("r27_res", 32'(result), 32'h0100);
    // Random operands changing every cycle, occasional reset
    for (int i = 0; i < 400; i++)
      step(WIDTH'($urandom_range(0, 255)), WIDTH'($urandom_range(0, 255)),
           ($urandom_range(0, 39) == 0));
    // Drain in-flight product
    for (int i = 0; i <= K && ph != 0; i++)
      step(WIDTH'($urandom), WIDTH'($urandom), 1'b0);
    @(negedge clk);
    #1;
    chk("drain", 32'(q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sequential_multiplier.md
SEQUENTIAL_MULTIPLIER -- requirements
Module: sequential_multiplier

Interface
REQ-001 Parameter WIDTH, default 8, operand width in bits.
REQ-002 Parameter DIGIT, default 4, multiplier bits consumed per cycle; WIDTH SHALL be an integer multiple of DIGIT.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge only.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-005 a  input  WIDTH  unsigned multiplicand.
REQ-006 b  input  WIDTH  unsigned multiplier.
REQ-007 result  output  2*WIDTH  registered unsigned product of the most recently completed operation.
REQ-008 busy  output  1  high while an operation is in CALC.
REQ-009 done  output  1  one-cycle pulse, high in the cycle after result updates.

Function
REQ-010 Free-running engine; there is no start input. States: LOAD and CALC.
REQ-011 LOAD, on a clock edge with reset low: capture a and b into internal operand registers, clear accumulator and digit counter, go to CALC.
REQ-012 CALC: each edge adds (a_reg * b_reg[DIGIT*i +: DIGIT]) << (DIGIT*i) to the accumulator, for i = 0 .. WIDTH/DIGIT-1, then increments i.
REQ-013 On the last digit edge, write the final sum to result, set done for exactly one cycle, and return to LOAD.
REQ-014 Latency: operands captured at edge N; result valid after edge N + WIDTH/DIGIT (edge N+2 with defaults); one product every WIDTH/DIGIT+1 cycles.
REQ-015 Operand changes on a or b during CALC SHALL NOT affect the in-flight product; they are captured at the next LOAD.
REQ-016 Arithmetic is unsigned; accumulator is 2*WIDTH bits and SHALL never overflow (max 255*255 = 0xFE01 for WIDTH=8).
REQ-017 result SHALL hold its value between updates; it is never cleared except by reset.
REQ-018 busy SHALL be high exactly in CALC cycles; done and busy SHALL never be high together.
REQ-019 Zero operands produce result 0 with the same latency; no early termination.

Reset
REQ-020 While reset is high at a rising edge: state = LOAD, result = 0, done = 0, busy = 0, accumulator, counter and operand registers = 0.
REQ-021 Reset asserted during CALC SHALL abort the operation; result keeps no partial value (it becomes 0).
REQ-022 The first LOAD capture occurs on the first rising edge with reset low.

Verification
REQ-023 reset high one edge, a=0x03, b=0x05 held -> result=0x0000 during reset, result=0x000F after the 3rd post-reset edge, done pulsed once.
REQ-024 a=0xFF, b=0xFF -> result=0xFE01; repeat a=0x00, b=0xA5 -> result=0x0000 with identical latency.
REQ-025 a=0x12, b=0x34 captured, then change to a=0x07, b=0x09 during CALC -> result=0x03A8, next product=0x003F.
REQ-026 Reset asserted on the 1st CALC edge of a=0xFF, b=0xFF -> result=0x0000, busy=0, engine restarts from LOAD after reset release.
REQ-027 Continuous run, a=0x10, b=0x10 -> done pulses every 3 cycles, result=0x0100 stable between pulses, busy pattern 0,1,1 repeating.
